// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 host transmitter: FSM states, abort
// cause codes, frame length and the odd-parity helper.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    SHIFT,
    ACK,
    WAIT_IDLE
  } state_e;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_NOACK   = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;

  // start + 8 data + parity + stop
  localparam int FRAME_BITS = 11;

  // Parity bit that makes the 9-bit (data + parity) word contain an odd number of ones.
  function automatic logic odd_parity(input logic [7:0] b);
    return ~(^b);
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchroniser followed by a 4-sample stable-level filter for one
// PS/2 line. The filtered output only changes after four equal samples and
// resets low, so the host treats the bus as busy until it has seen it idle.
module ps2_line_sync (
  input  logic clk,
  input  logic reset,
  input  logic line_i,
  output logic filt_o
);

  logic [1:0] sync_q;
  logic [3:0] hist_q;
  logic       filt_q;

  // Synchronise, keep a 4-deep sample history, update level on a stable run.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= 2'b00;
      hist_q <= 4'b0000;
      filt_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], line_i};
      hist_q <= {hist_q[2:0], sync_q[1]};
      if (&hist_q)       filt_q <= 1'b1;
      else if (~|hist_q) filt_q <= 1'b0;
    end
  end

  assign filt_o = filt_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter. Inhibits the clock, issues the
// request-to-send, shifts a byte + odd parity + stop on device falling edges
// and checks the device ACK.
// Optional frame watchdog compiled in with macro PS2_TX_TIMEOUT_EN.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 10000,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [1:0] err_code
);

  logic clk_f, dat_f, clk_prev_q, fall;

  ps2_line_sync u_sync_clk (.clk(clk), .reset(reset), .line_i(ps2_clk_in),  .filt_o(clk_f));
  ps2_line_sync u_sync_dat (.clk(clk), .reset(reset), .line_i(ps2_data_in), .filt_o(dat_f));

  assign fall = clk_prev_q & ~clk_f;

  state_e      state_q, state_d;
  logic [7:0]  data_q, data_d;
  logic        par_q, par_d;
  logic [3:0]  edge_q, edge_d;   // device falling edges seen this frame
  logic        drive_q, drive_d; // data_oe level while shifting
  logic [31:0] inh_q, inh_d;
  logic [1:0]  code_q, code_d;
  logic        rdy;
`ifdef PS2_TX_TIMEOUT_EN
  logic [31:0] wd_q, wd_d;
`endif

  // Next-state and output decode.
  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    par_d       = par_q;
    edge_d      = edge_q;
    drive_d     = drive_q;
    inh_d       = inh_q;
    code_d      = code_q;
    rdy         = 1'b0;
    ps2_clk_oe  = 1'b0;
    ps2_data_oe = 1'b0;
    busy        = (state_q != IDLE);
    done        = 1'b0;
    err         = 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
    wd_d        = wd_q;
`endif
    case (state_q)
      IDLE: begin
        rdy = clk_f & dat_f;
        if (tx_valid && rdy) begin
          state_d = INHIBIT;
          data_d  = tx_data;
          par_d   = odd_parity(tx_data);
          edge_d  = 4'd0;
          inh_d   = 32'd0;
          drive_d = 1'b0;
          code_d  = ERR_NONE;
          busy    = 1'b1;
`ifdef PS2_TX_TIMEOUT_EN
          wd_d    = 32'd0;
`endif
        end
      end
      INHIBIT: begin
        ps2_clk_oe = 1'b1;
        if (inh_q == 32'(INHIBIT_CYCLES - 1)) begin
          ps2_data_oe = 1'b1;
          state_d     = REQ;
        end else begin
          inh_d = inh_q + 32'd1;
        end
      end
      REQ: begin
        ps2_data_oe = 1'b1;
        drive_d     = 1'b1;
        state_d     = SHIFT;
      end
      SHIFT: begin
        ps2_data_oe = drive_q;
        if (fall) begin
          edge_d = edge_q + 4'd1;
          if (edge_q < 4'd8)       drive_d = ~data_q[edge_q[2:0]];
          else if (edge_q == 4'd8) drive_d = ~par_q;
          else begin
            drive_d = 1'b0;
            state_d = ACK;
          end
        end
      end
      ACK: begin
        if (fall) begin
          edge_d = edge_q + 4'd1;
          if (!dat_f) state_d = WAIT_IDLE;
          else begin
            err     = 1'b1;
            code_d  = ERR_NOACK;
            state_d = IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        if (clk_f && dat_f) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
`ifdef PS2_TX_TIMEOUT_EN
    // Watchdog overrides whatever the frame was doing.
    if (state_q != IDLE) begin
      wd_d = wd_q + 32'd1;
      if (wd_q == 32'(TIMEOUT_CYCLES - 1)) begin
        state_d     = IDLE;
        ps2_clk_oe  = 1'b0;
        ps2_data_oe = 1'b0;
        done        = 1'b0;
        err         = 1'b1;
        code_d      = ERR_TIMEOUT;
      end
    end
`endif
    // A reset cycle must never report a frame outcome.
    if (reset) begin
      done = 1'b0;
      err  = 1'b0;
    end
  end

  assign tx_ready = rdy;
  // Show the new cause in the err cycle itself; it then holds until the next accept.
  assign err_code = code_d;

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      data_q     <= 8'd0;
      par_q      <= 1'b0;
      edge_q     <= 4'd0;
      drive_q    <= 1'b0;
      inh_q      <= 32'd0;
      code_q     <= ERR_NONE;
      clk_prev_q <= 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
      wd_q       <= 32'd0;
`endif
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      par_q      <= par_d;
      edge_q     <= edge_d;
      drive_q    <= drive_d;
      inh_q      <= inh_d;
      code_q     <= code_d;
      clk_prev_q <= clk_f;
`ifdef PS2_TX_TIMEOUT_EN
      wd_q       <= wd_d;
`endif
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx with a behavioural PS/2 device model.
// Timing is scaled down (short inhibit, fast device clock, short watchdog)
// so every scenario fits in a short run.
module tb_ps2_host_tx;
  localparam int INH = 200;
  localparam int TO  = 3000;
  localparam int H   = 30;   // device clock half period in clk cycles

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, ps2_clk_oe, ps2_data_oe, busy, done, err;
  logic [1:0] err_code;
  logic       dev_clk = 1'b1, dev_dat = 1'b1;
  logic       ps2_clk_in, ps2_data_in;

  // Open-collector bus with pull-ups.
  assign ps2_clk_in  = ~ps2_clk_oe  & dev_clk;
  assign ps2_data_in = ~ps2_data_oe & dev_dat;

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
    .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe), .busy(busy),
    .done(done), .err(err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int cyc = 0, done_cnt = 0, err_cnt = 0, acc_cnt = 0, dbl_cnt = 0;
  int acc_cyc = 0, err_cyc = 0, done_cyc = 0;
  logic [1:0] last_code = 2'd0;
  int inh_run = 0, inh_dat = 0, inh_len = 0, inh_dat_seen = 0;
  logic inh_dat_last = 1'b0, prev_clk_oe = 1'b0, prev_dat_oe = 1'b0;
  int dev_i = 0;
  bit abort = 0;

  // Passive monitor, sampled mid-cycle.
  always @(negedge clk) begin
    cyc++;
    if (tx_valid && tx_ready) begin acc_cnt++; acc_cyc = cyc; end
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (err) begin err_cnt++; err_cyc = cyc; last_code = err_code; end
    if (done && err) dbl_cnt++;
    if (ps2_clk_oe) begin
      inh_run++;
      if (ps2_data_oe) inh_dat++;
    end else if (prev_clk_oe) begin
      inh_len = inh_run; inh_dat_seen = inh_dat; inh_dat_last = prev_dat_oe;
      inh_run = 0; inh_dat = 0;
    end
    prev_clk_oe = ps2_clk_oe;
    prev_dat_oe = ps2_data_oe;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference frame: start 0, data LSB first, odd parity, stop 1.
  function automatic logic [10:0] ref_frame(input logic [7:0] b);
    int ones = 0;
    for (int k = 0; k < 8; k++) if (b[k]) ones++;
    return {1'b1, (ones % 2 == 0) ? 1'b1 : 1'b0, b, 1'b0};
  endfunction

  // Device model: waits for the request, clocks 11 bits, samples the host
  // data on each rising edge and optionally ACKs on the 11th clock.
  task automatic dev_frame(input bit ack, output logic [10:0] got, output bit ok);
    int b;
    got = '0; ok = 1;
    b = 0;
    while (!ps2_clk_oe && b < 200) begin tick(1); b++; end
    b = 0;
    while (ps2_clk_oe && b < INH + 50) begin tick(1); b++; end
    if (ps2_clk_oe || b == 0) begin ok = 0; return; end
    got[0] = ps2_data_in;
    tick(H);
    for (int i = 1; i <= 11; i++) begin
      if (abort) begin dev_clk = 1'b1; dev_dat = 1'b1; return; end
      dev_i = i;
      dev_clk = 1'b0;
      tick(H);
      if (i <= 10) got[i] = ps2_data_in;
      dev_clk = 1'b1;
      if (i == 10 && ack) dev_dat = 1'b0;
      tick(H);
    end
    dev_dat = 1'b1;
    dev_i = 0;
  endtask

  task automatic send_req(input logic [7:0] b, input bit hold);
    int a0 = acc_cnt;
    int n = 0;
    tx_data = b; tx_valid = 1'b1;
    while (acc_cnt == a0 && n < 100) begin tick(1); n++; end
    if (!hold) tx_valid = 1'b0;
    checks++;
    if (acc_cnt != a0 + 1) begin errors++; $display("FAIL accept got %0d exp %0d", acc_cnt - a0, 1); end
  endtask

  task automatic wait_end(input int d0, input int e0);
    int n = 0;
    while (done_cnt == d0 && err_cnt == e0 && n < 300) begin tick(1); n++; end
    tick(2);
  endtask

  task automatic run_frame(input string nm, input logic [7:0] b, input bit ack);
    logic [10:0] got;
    bit ok;
    int d0 = done_cnt, e0 = err_cnt;
    send_req(b, 0);
    tx_data = ~b;   // must not affect the frame in flight
    dev_frame(ack, got, ok);
    wait_end(d0, e0);
    checks++;
    if (!ok || got !== ref_frame(b)) begin errors++; $display("FAIL %s bits got %h exp %h", nm, got, ref_frame(b)); end
    checks++;
    if (inh_len != INH || inh_dat_seen != 1 || inh_dat_last !== 1'b1) begin
      errors++; $display("FAIL %s inhibit got len %0d dat %0d last %b exp %0d 1 1", nm, inh_len, inh_dat_seen, inh_dat_last, INH);
    end
    checks++;
    if (done_cnt - d0 != (ack ? 1 : 0) || err_cnt - e0 != (ack ? 0 : 1)) begin
      errors++; $display("FAIL %s pulses got done %0d err %0d exp ack=%0d", nm, done_cnt - d0, err_cnt - e0, ack);
    end
    checks++;
    if (err_code !== (ack ? 2'd0 : 2'd1) || (!ack && last_code !== 2'd1)) begin
      errors++; $display("FAIL %s err_code got %0d/%0d exp %0d", nm, err_code, last_code, ack ? 0 : 1);
    end
    checks++;
    if (busy !== 1'b0 || ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0) begin
      errors++; $display("FAIL %s idle got busy %b oe %b%b exp 0 00", nm, busy, ps2_clk_oe, ps2_data_oe);
    end
  endtask

  task automatic test_reset;
    tick(3);
    checks++;
    if ({ps2_clk_oe, ps2_data_oe, busy, done, err, err_code, tx_ready} !== 8'd0) begin
      errors++; $display("FAIL reset got %b exp 00000000", {ps2_clk_oe, ps2_data_oe, busy, done, err, err_code, tx_ready});
    end
    reset = 1'b0;
    tick(20);
    checks++;
    if (tx_ready !== 1'b1) begin errors++; $display("FAIL ready_after_reset got %b exp 1", tx_ready); end
  endtask

  task automatic test_known;
    run_frame("send_ED", 8'hED, 1);
    run_frame("send_F4", 8'hF4, 1);
  endtask

  task automatic test_nack;
    run_frame("nack", 8'($urandom_range(0, 255)), 0);
  endtask

  task automatic test_random;
    for (int k = 0; k < 5; k++) run_frame("random", 8'($urandom_range(0, 255)), ($urandom_range(0, 3) != 0));
  endtask

  task automatic test_reset_mid;
    logic [10:0] got;
    bit ok;
    int d0 = done_cnt, e0 = err_cnt;
    abort = 0;
    send_req(8'($urandom_range(0, 255)), 0);
    fork
      dev_frame(1, got, ok);
      begin
        int n = 0;
        while (dev_i != 4 && n < 2000) begin tick(1); n++; end
        tick(H / 2);
        abort = 1;
        reset = 1'b1;
        tick(1);
        checks++;
        if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0 || busy !== 1'b0 || n >= 2000) begin
          errors++; $display("FAIL reset_mid got oe %b%b busy %b exp 00 0", ps2_clk_oe, ps2_data_oe, busy);
        end
        reset = 1'b0;
      end
    join
    tick(20);
    abort = 0;
    checks++;
    if (done_cnt != d0 || err_cnt != e0) begin
      errors++; $display("FAIL reset_mid_pulses got %0d %0d exp 0 0", done_cnt - d0, err_cnt - e0);
    end
  endtask

  task automatic test_back_to_back;
    logic [10:0] got;
    bit ok;
    logic [7:0] b1 = 8'($urandom_range(0, 255));
    logic [7:0] b2 = b1 ^ 8'h5A;
    int d0, a0;
    d0 = done_cnt;
    send_req(b1, 1);
    a0 = acc_cnt;
    tx_data = b2;
    dev_frame(1, got, ok);
    checks++;
    if (!ok || got !== ref_frame(b1)) begin errors++; $display("FAIL b2b_first got %h exp %h", got, ref_frame(b1)); end
    wait_end(d0, err_cnt);
    checks++;
    if (done_cnt != d0 + 1 || acc_cnt != a0 + 1 || acc_cyc <= done_cyc) begin
      errors++; $display("FAIL b2b_order got done %0d acc %0d exp 1 1 after done", done_cnt - d0, acc_cnt - a0);
    end
    tx_valid = 1'b0;
    d0 = done_cnt;
    dev_frame(1, got, ok);
    wait_end(d0, err_cnt);
    checks++;
    if (!ok || got !== ref_frame(b2) || done_cnt != d0 + 1) begin
      errors++; $display("FAIL b2b_second got %h exp %h", got, ref_frame(b2));
    end
  endtask

  task automatic test_timeout;
    int e0 = err_cnt;
    send_req(8'($urandom_range(0, 255)), 0);
`ifdef PS2_TX_TIMEOUT_EN
    begin
      int n = 0;
      while (err_cnt == e0 && n < TO + 100) begin tick(1); n++; end
    end
    tick(1);
    checks++;
    if (err_cnt != e0 + 1 || err_cyc - acc_cyc != TO || last_code !== 2'd2) begin
      errors++; $display("FAIL timeout got err %0d dt %0d code %0d exp 1 %0d 2", err_cnt - e0, err_cyc - acc_cyc, last_code, TO);
    end
    checks++;
    if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL timeout_release got oe %b%b busy %b exp 00 0", ps2_clk_oe, ps2_data_oe, busy);
    end
`else
    tick(2 * TO);
    checks++;
    if (busy !== 1'b1 || err_cnt != e0) begin
      errors++; $display("FAIL no_timeout got busy %b err %0d exp 1 0", busy, err_cnt - e0);
    end
    reset = 1'b1; tick(2); reset = 1'b0; tick(20);
`endif
  endtask

  initial begin
    test_reset;
    test_known;
    test_nack;
    test_random;
    test_reset_mid;
    test_back_to_back;
    test_timeout;
    checks++;
    if (dbl_cnt != 0) begin errors++; $display("FAIL done_err_same_cycle got %0d exp 0", dbl_cnt); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 SHALL have parameter INHIBIT_CYCLES, default 10000, clock-inhibit length in clk cycles (100 us at 100 MHz).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 2000000, maximum clk cycles for one frame before abort (20 ms).
REQ-003 SHALL have the following ports, one per line:
- clk  input  1  system clock (100 MHz); the block uses one clock.
- reset  input  1  synchronous, active-high reset.
- tx_data  input  8  command byte to send.
- tx_valid  input  1  request to send tx_data.
- tx_ready  output  1  high when a request is accepted.
- ps2_clk_in  input  1  raw PS/2 clock pin level.
- ps2_data_in  input  1  raw PS/2 data pin level.
- ps2_clk_oe  output  1  1 pulls the PS/2 clock low; 0 releases it.
- ps2_data_oe  output  1  1 pulls the PS/2 data low; 0 releases it.
- busy  output  1  frame in progress; the receiver ignores the bus while this is high.
- done  output  1  one-cycle pulse when a frame is acknowledged.
- err  output  1  one-cycle pulse when a frame is aborted.
- err_code  output  2  cause of the abort (0 none, 1 no ACK, 2 timeout); held until the next accept.

Function
REQ-004 SHALL synchronise ps2_clk_in and ps2_data_in through 2 flops, then apply a 4-sample stable-level filter; a falling edge is detected on the filtered clock only.
REQ-005 SHALL accept a request when tx_valid and tx_ready are both high; tx_ready is high only in IDLE with the filtered clock and data both high.
REQ-006 SHALL use the states IDLE, INHIBIT, REQ, SHIFT, ACK, WAIT_IDLE.
- IDLE: accept the request → INHIBIT.
- INHIBIT: ps2_clk_oe=1 for exactly INHIBIT_CYCLES; ps2_data_oe=1 in the final cycle → REQ.
- REQ: ps2_clk_oe=0, ps2_data_oe=1 (start bit) → SHIFT.
- SHIFT: on each device falling edge n=1..10, set the data line: n=1..8 gives tx_data[n-1] (LSB first); n=9 gives odd parity; n=10 releases the line (stop bit). Each bit drives data_oe = ~bit. After n=10 → ACK.
- ACK: on the 11th falling edge, sample the filtered data. Low → WAIT_IDLE. High → err with err_code=1 → IDLE.
- WAIT_IDLE: when the filtered clock and data are both high, pulse done → IDLE.
REQ-007 SHALL latch tx_data and compute parity at accept; tx_data changes after accept have no effect.
REQ-008 SHALL hold busy high from the accept cycle until the cycle of done/err inclusive.
REQ-009 SHALL assert done and err in separate cycles only; at most one pulse per frame.
REQ-010 SHALL ignore tx_valid while busy; no request is queued.
REQ-011 SHALL count device falling edges with a 4-bit counter; a count outside 1..11 is unreachable.

Reset
REQ-012 SHALL on reset enter IDLE with ps2_clk_oe=0, ps2_data_oe=0, busy=0, done=0, err=0, err_code=0, and tx_ready=0 until the filtered lines read high.
REQ-013 SHALL on reset asserted mid-frame release both lines on the next clk edge, with no done/err pulse.

Configuration
REQ-014 SHALL compile the frame watchdog only with macro PS2_TX_TIMEOUT_EN.
- Defined: a counter is cleared at accept and runs in every non-IDLE state. Reaching TIMEOUT_CYCLES releases both lines, pulses err with err_code=2, and returns to IDLE.
- Undefined: there is no counter and err_code=2 never occurs; the block waits indefinitely for device clocks.

Structure
REQ-015 SHALL place the state enum, the err_code constants (ERR_NONE, ERR_NOACK, ERR_TIMEOUT) and the PS/2 frame length (11) in the shared package ps2_pkg.
REQ-016 SHALL implement the synchroniser and filter (REQ-004) as sub-module ps2_line_sync, instantiated once per line.

Verification
REQ-017 SHALL cover, with a bench device model clocking at 12.5 kHz and ACKing by default:
- Send 0xED: clock low for 10000 cycles; bits 1,0,1,1,0,1,1,1; parity 1; stop released; ACK low → one done pulse, err_code=0.
- Send 0xF4: bits 0,0,1,0,1,1,1,1; parity 0 → done.
- Model holds data high on edge 11 → err pulse, err_code=1, no done, both lines released.
- PS2_TX_TIMEOUT_EN defined, model never clocks → err with err_code=2 exactly 2000000 cycles after accept; undefined → busy stays high.
- Reset asserted during bit 4 → ps2_clk_oe=0 and ps2_data_oe=0 on the next cycle, busy=0, no pulses.
- tx_valid held high through a frame → exactly one frame sent; a second frame starts only after done and a tx_ready cycle.
